linear_interp_up: RTL and testbench

Sample-rate upsampler with linear interpolation for the audio datapath. It is the interpolating counterpart to the averaging lowpass/decimation chain. Each accepted signed input sample produces 2^`interp_sel` output samples. The outputs step linearly from the previous input sample toward the new one. Input and output use valid/ready handshakes, so the block sits between a slow sample source and a faster DAC/processing stage.

---
 rtl/linear_interp_up.sv | 83 ++++++++
 tb/tb_linear_interp_up.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_interp_up.sv
// Linear-interpolating upsampler: each accepted sample yields 2^interp_sel outputs stepping from prev toward d.
// Latency 1 cycle from input accept to first output; in_ready is low for the whole burst and output holds under backpressure.
module linear_interp_up #(
    parameter int BIT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic [2:0]           interp_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] q
);

    localparam int AW = BIT_WIDTH + 8;
    localparam int SW = BIT_WIDTH + 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                      state;
    logic signed [BIT_WIDTH-1:0] prev;
    logic [2:0]                  k;
    logic [6:0]                  cnt;
    logic signed [AW-1:0]        acc;
    logic signed [SW-1:0]        step;

    logic signed [AW-1:0]        prev_ext;
    logic signed [AW-1:0]        acc_next;
    logic [6:0]                  last_idx;

    assign in_ready = (state == IDLE);
    assign prev_ext = {{8{prev[BIT_WIDTH-1]}}, prev};
    assign acc_next = acc + {{(AW-SW){step[SW-1]}}, step};
    assign last_idx = 7'((8'd1 << k) - 8'd1);

    // acc holds prev*L + i*step exactly; the shift by k is the floor divide by L.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            q         <= '0;
            prev      <= '0;
            acc       <= '0;
            step      <= '0;
            cnt       <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k         <= interp_sel;
                        step      <= {d[BIT_WIDTH-1], d} - {prev[BIT_WIDTH-1], prev};
                        acc       <= prev_ext <<< interp_sel;
                        q         <= prev;
                        prev      <= d;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (cnt == last_idx) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            acc <= acc_next;
                            q   <= BIT_WIDTH'(acc_next >>> k);
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_interp_up.sv
// Bench for linear_interp_up: stimulus tasks push expected outputs to a queue, a monitor pops on each output transfer.
module tb_linear_interp_up;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b0;
    logic [2:0]  interp_sel = 3'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] d = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] q;

    int     n_checks = 0;
    int     n_pass = 0;
    int     n_out = 0;
    int     mon_e;
    longint model_prev = 0;
    int     exp_q[$];

    linear_interp_up #(.BIT_WIDTH(24)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .interp_sel (interp_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aclr_n && out_valid && out_ready) begin
            n_out++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected got q=%0d expected no output", $signed(q));
            end else begin
                mon_e = exp_q.pop_front();
                if ($signed(q) !== mon_e)
                    $display("FAIL sb_q output %0d got %0d expected %0d", n_out, $signed(q), mon_e);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_expected(input longint dv, input int sel);
        longint l = longint'(1) << sel;
        for (int i = 0; i < l; i++)
            exp_q.push_back(int'((model_prev * l + longint'(i) * (dv - model_prev)) >>> sel));
        model_prev = dv;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int dv, input int sel);
        bit ok = 1'b0;
        interp_sel = 3'(sel);
        d          = 24'(dv);
        in_valid   = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!ok) $display("FAIL send_timeout d=%0d in_ready got 0 expected 1", dv);
        else begin
            n_pass++;
            push_expected(longint'(dv), sel);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL drain_timeout pending got %0d expected 0", exp_q.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        aclr_n = 1'b0;
        exp_q.delete();
        model_prev = 0;
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_out_valid got %b expected 0", tag, out_valid);
        else n_pass++;
        n_checks++;
        if (q !== 24'd0) $display("FAIL %s_q got %0d expected 0", tag, $signed(q));
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s_in_ready got %b expected 1", tag, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        check_idle_outputs("reset_init");
        #20;
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
        send(1000, 3);
        repeat (3) @(posedge clk);
        #3;
        aclr_n = 1'b0;
        #1;
        check_idle_outputs("reset_midburst");
        exp_q.delete();
        model_prev = 0;
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
    endtask

    task automatic check_block(input string tag);
        int c = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            c++;
            if (in_ready) break;
        end
        n_checks++;
        if (c !== 5) $display("FAIL %s_in_ready_block got %0d cycles expected 5", tag, c);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        send(400, 2);
        check_block("ramp_up");
        send(0, 2);
        check_block("ramp_down");
        drain();
    endtask

    task automatic test_floor();
        do_reset();
        send(-3, 1);
        send(3, 1);
        drain();
    endtask

    task automatic test_backpressure();
        int     xfer = 0;
        int     base = n_out;
        longint p0 = model_prev;
        int     q2 = int'((p0 * 8 + 2 * (80 - p0)) >>> 3);
        send(80, 3);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) xfer++;
            @(posedge clk);
            #1;
            if (xfer == 2) break;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cycle %0d got %b expected 1", c, out_valid);
            else n_pass++;
            n_checks++;
            if ($signed(q) !== q2) $display("FAIL bp_hold_q cycle %0d got %0d expected %0d", c, $signed(q), q2);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        n_checks++;
        if (n_out - base !== 8) $display("FAIL bp_count got %0d expected 8", n_out - base);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        int base;
        do_reset();
        base = n_out;
        send(5, 0);
        send(7, 0);
        send(9, 0);
        drain();
        n_checks++;
        if (n_out - base !== 3) $display("FAIL pass_count got %0d expected 3", n_out - base);
        else n_pass++;
        base = n_out;
        send(100, 2);
        interp_sel = 3'd7;
        drain();
        n_checks++;
        if (n_out - base !== 4) $display("FAIL latch_count got %0d expected 4", n_out - base);
        else n_pass++;
    endtask

    task automatic test_full_scale();
        int idx = 0;
        int last = 0;
        send(-8388608, 0);
        drain();
        send(8388607, 7);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (idx == 0) begin
                    n_checks++;
                    if ($signed(q) !== -8388608) $display("FAIL fs_first got %0d expected -8388608", $signed(q));
                    else n_pass++;
                end else begin
                    n_checks++;
                    if ($signed(q) < last) $display("FAIL fs_monotonic idx %0d got %0d expected >= %0d", idx, $signed(q), last);
                    else n_pass++;
                end
                if (idx == 127) begin
                    n_checks++;
                    if ($signed(q) !== 8257535) $display("FAIL fs_last got %0d expected 8257535", $signed(q));
                    else n_pass++;
                end
                last = int'($signed(q));
                idx++;
                if (idx == 128) break;
            end
        end
        n_checks++;
        if (idx !== 128) $display("FAIL fs_count got %0d expected 128", idx);
        else n_pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_floor();
        test_backpressure();
        test_passthrough();
        test_full_scale();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
